// File: rtl/mdio_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdio_resp_pkg
// Purpose  : Shared constants for the Clause-22 MDIO responder: FSM state
//            encoding, opcode values, preamble length and field widths.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mdio_resp_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;

  // Saturation point of the preamble ones counter.
  localparam logic [5:0] PREAMBLE_LEN = 6'd32;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  // Frame decoder state encoding.
  localparam logic [2:0] S_PRE   = 3'd0;
  localparam logic [2:0] S_ST    = 3'd1;
  localparam logic [2:0] S_OP    = 3'd2;
  localparam logic [2:0] S_PHYAD = 3'd3;
  localparam logic [2:0] S_REGAD = 3'd4;
  localparam logic [2:0] S_TA    = 3'd5;
  localparam logic [2:0] S_WDATA = 3'd6;
  localparam logic [2:0] S_RDATA = 3'd7;

  function automatic logic op_is_valid(input logic [1:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdio_sync.sv
`default_nettype none
// ============================================================================
// Module   : mdio_sync
// Purpose  : 2-FF synchronizers for the asynchronous MDC and MDIO pad inputs,
//            plus a registered single-cycle MDC rising-edge pulse. The MDIO
//            sample is delayed to line up with the edge pulse.
// Ports    : clk, rst      - system clock, synchronous active-high reset
//            mdc, mdio     - raw pad inputs
//            mdc_rise      - 1-cycle pulse, 3 clk after the MDC pin rises
//            mdio_bit      - MDIO value associated with mdc_rise
// Revision : 1.0 - initial release
// ============================================================================
module mdio_sync (
  input  logic clk,
  input  logic rst,
  input  logic mdc,
  input  logic mdio,
  output logic mdc_rise,
  output logic mdio_bit
);

  // [0],[1] form the synchronizer; [2] is the history tap for edge detect.
  logic [2:0] mdc_ff;
  logic [1:0] mdio_ff;

  always_ff @(posedge clk) begin
    if (rst) begin
      mdc_ff   <= 3'b000;
      mdio_ff  <= 2'b00;
      mdc_rise <= 1'b0;
      mdio_bit <= 1'b0;
    end else begin
      mdc_ff   <= {mdc_ff[1:0], mdc};
      mdio_ff  <= {mdio_ff[0], mdio};
      mdc_rise <= mdc_ff[1] & ~mdc_ff[2];
      mdio_bit <= mdio_ff[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mdio_responder.sv
`default_nettype none
// ============================================================================
// Module   : mdio_responder
// Purpose  : Clause-22 MDIO management responder (PHY side). Decodes read and
//            write frames addressed to PHY_ADDR and drives a simple register
//            access port. The MDIO line is driven only during read TA bit 2
//            and the 16 read data bits; the parent wires o_mdio/o_mdio_t/
//            i_mdio to an iobuf_tech pad.
// Ports    : i_clk, i_rst          - system clock (>= 8x MDC), sync reset
//            i_mdc, i_mdio         - asynchronous pad inputs
//            o_mdio, o_mdio_t      - pad drive value and tristate (1 = Z)
//            o_reg_addr            - register address of current/last frame
//            o_reg_rd, i_reg_rdata - read strobe; data valid 2 clk later
//            o_reg_wr, o_reg_wdata - write strobe and data
//            o_frame_err           - pulse on invalid ST or OP
// Config   : MDIO_RESP_PREAMBLE_SUPPRESS_EN - when defined, a single preamble
//            one is enough to accept ST; otherwise 32 ones are required.
// Revision : 1.0 - initial release
// ============================================================================
module mdio_responder
  import mdio_resp_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PHY_ADDR = 5'd1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_mdc,
  input  logic              i_mdio,
  output logic              o_mdio,
  output logic              o_mdio_t,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic              o_reg_rd,
  input  logic [DATA_W-1:0] i_reg_rdata,
  output logic              o_reg_wr,
  output logic [DATA_W-1:0] o_reg_wdata,
  output logic              o_frame_err
);

`ifdef MDIO_RESP_PREAMBLE_SUPPRESS_EN
  localparam logic [5:0] PRE_REQ = 6'd1;
`else
  localparam logic [5:0] PRE_REQ = PREAMBLE_LEN;
`endif

  logic              mdc_rise;
  logic              mdio_bit;

  logic [2:0]        state;
  logic [5:0]        pre_cnt;
  logic [3:0]        bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [1:0]        op;
  logic [DATA_W-1:0] rdata_sh;
  logic              rd_d1;
  logic              rd_d2;
  logic [ADDR_W-1:0] field5;

  mdio_sync u_sync (
    .clk      (i_clk),
    .rst      (i_rst),
    .mdc      (i_mdc),
    .mdio     (i_mdio),
    .mdc_rise (mdc_rise),
    .mdio_bit (mdio_bit)
  );

  // 5-bit field including the bit arriving on this edge.
  assign field5 = {shreg[3:0], mdio_bit};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_PRE;
      pre_cnt     <= 6'd0;
      bit_cnt     <= 4'd0;
      shreg       <= '0;
      op          <= 2'b00;
      rdata_sh    <= '0;
      rd_d1       <= 1'b0;
      rd_d2       <= 1'b0;
      o_mdio      <= 1'b0;
      o_mdio_t    <= 1'b1;
      o_reg_addr  <= '0;
      o_reg_rd    <= 1'b0;
      o_reg_wr    <= 1'b0;
      o_reg_wdata <= '0;
      o_frame_err <= 1'b0;
    end else begin
      o_reg_rd    <= 1'b0;
      o_reg_wr    <= 1'b0;
      o_frame_err <= 1'b0;

      // Register file returns data two cycles after the read strobe; the
      // capture always lands well before TA ends at the minimum clock ratio.
      rd_d1 <= o_reg_rd;
      rd_d2 <= rd_d1;
      if (rd_d2) begin
        rdata_sh <= i_reg_rdata;
      end

      if (mdc_rise) begin
        case (state)
          S_PRE: begin
            if (mdio_bit) begin
              if (pre_cnt != PREAMBLE_LEN) begin
                pre_cnt <= pre_cnt + 6'd1;
              end
            end else begin
              // This zero is the first ST bit when the preamble was long enough.
              pre_cnt <= 6'd0;
              if (pre_cnt >= PRE_REQ) begin
                state <= S_ST;
              end
            end
          end

          S_ST: begin
            bit_cnt <= 4'd0;
            if (mdio_bit) begin
              state <= S_OP;
            end else begin
              o_frame_err <= 1'b1;
              state       <= S_PRE;
            end
          end

          S_OP: begin
            shreg   <= {shreg[DATA_W-2:0], mdio_bit};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd1) begin
              bit_cnt <= 4'd0;
              op      <= {shreg[0], mdio_bit};
              if (op_is_valid({shreg[0], mdio_bit})) begin
                state <= S_PHYAD;
              end else begin
                o_frame_err <= 1'b1;
                state       <= S_PRE;
              end
            end
          end

          S_PHYAD: begin
            shreg   <= {shreg[DATA_W-2:0], mdio_bit};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd4) begin
              bit_cnt <= 4'd0;
              // A frame for another PHY is dropped without any indication.
              state   <= (field5 == PHY_ADDR) ? S_REGAD : S_PRE;
            end
          end

          S_REGAD: begin
            shreg   <= {shreg[DATA_W-2:0], mdio_bit};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd4) begin
              bit_cnt    <= 4'd0;
              o_reg_addr <= field5;
              o_reg_rd   <= (op == OP_READ);
              state      <= S_TA;
            end
          end

          S_TA: begin
            bit_cnt <= bit_cnt + 4'd1;
            if (op == OP_READ) begin
              if (bit_cnt == 4'd0) begin
                // Take the line for TA bit 2 and present the required zero.
                o_mdio_t <= 1'b0;
                o_mdio   <= 1'b0;
              end else begin
                o_mdio  <= rdata_sh[DATA_W-1];
                bit_cnt <= 4'd0;
                state   <= S_RDATA;
              end
            end else if (bit_cnt == 4'd1) begin
              bit_cnt <= 4'd0;
              state   <= S_WDATA;
            end
          end

          S_RDATA: begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
              // Bit 0 has been on the line for a full period.
              o_mdio_t <= 1'b1;
              o_mdio   <= 1'b0;
              bit_cnt  <= 4'd0;
              state    <= S_PRE;
            end else begin
              o_mdio <= rdata_sh[4'd14 - bit_cnt];
            end
          end

          S_WDATA: begin
            shreg   <= {shreg[DATA_W-2:0], mdio_bit};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
              o_reg_wdata <= {shreg[DATA_W-2:0], mdio_bit};
              o_reg_wr    <= 1'b1;
              bit_cnt     <= 4'd0;
              state       <= S_PRE;
            end
          end

          default: begin
            state   <= S_PRE;
            pre_cnt <= 6'd0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdio_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mdio_responder
// Purpose  : Self-checking bench for mdio_responder. A master task bit-bangs
//            MDC/MDIO frames; expected register-port strobes are queued and a
//            monitor pops and compares them as the DUT raises them. Bus
//            read-back, TA, pad release and reset behaviour are checked
//            directly against hand-computed constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdio_responder;
  import mdio_resp_pkg::*;

  localparam int K_RD  = 0;
  localparam int K_WR  = 1;
  localparam int K_ERR = 2;

  typedef struct {
    int          kind;
    logic [4:0]  addr;
    logic [15:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mdc;
  logic        master_bit;
  wire         mdio_line;
  logic        o_mdio;
  logic        o_mdio_t;
  logic [4:0]  o_reg_addr;
  logic        o_reg_rd;
  logic [15:0] i_reg_rdata;
  logic        o_reg_wr;
  logic [15:0] o_reg_wdata;
  logic        o_frame_err;

  int  checks = 0;
  int  errors = 0;
  int  viol   = 0;
  logic allow_drive = 1'b0;

  ev_t exp_q[$];
  ev_t exp_e;
  int  got_kind;

  logic [15:0] regs [32];
  logic        rd_p1 = 1'b0;

  always #5 clk = ~clk;

  // Open-drain style bus with pull-up: master releases by driving 1.
  assign mdio_line = o_mdio_t ? master_bit : o_mdio;

  mdio_responder #(.PHY_ADDR(5'd1)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_mdc       (mdc),
    .i_mdio      (mdio_line),
    .o_mdio      (o_mdio),
    .o_mdio_t    (o_mdio_t),
    .o_reg_addr  (o_reg_addr),
    .o_reg_rd    (o_reg_rd),
    .i_reg_rdata (i_reg_rdata),
    .o_reg_wr    (o_reg_wr),
    .o_reg_wdata (o_reg_wdata),
    .o_frame_err (o_frame_err)
  );

  // Register file: data is valid only in the cycle two after the strobe.
  always @(posedge clk) begin
    rd_p1       <= o_reg_rd;
    i_reg_rdata <= rd_p1 ? regs[o_reg_addr] : 16'hDEAD;
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (!allow_drive && o_mdio_t !== 1'b1) viol++;
      if (o_reg_rd && o_reg_wr) viol++;
      if (o_reg_rd || o_reg_wr || o_frame_err) begin
        got_kind = o_reg_rd ? K_RD : (o_reg_wr ? K_WR : K_ERR);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe kind=%0d addr=%h wdata=%h required=no_strobe",
                   got_kind, o_reg_addr, o_reg_wdata);
        end else begin
          exp_e = exp_q.pop_front();
          if (got_kind != exp_e.kind ||
              (got_kind != K_ERR && o_reg_addr != exp_e.addr) ||
              (got_kind == K_WR && o_reg_wdata != exp_e.data)) begin
            errors++;
            $display("FAIL strobe kind=%0d addr=%h wdata=%h required kind=%0d addr=%h wdata=%h",
                     got_kind, o_reg_addr, o_reg_wdata, exp_e.kind, exp_e.addr, exp_e.data);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  task automatic push(input int kind, input logic [4:0] addr, input logic [15:0] data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // One MDC period; the bus is sampled just before MDC rises.
  task automatic mbit(input logic b, output logic smp);
    mdc        = 1'b0;
    master_bit = b;
    #80;
    smp = mdio_line;
    mdc = 1'b1;
    #80;
  endtask

  task automatic frame(input int npre, input logic [1:0] opc, input logic [4:0] phy,
                       input logic [4:0] ra, input logic [15:0] wd, input int abort_bit,
                       output logic ta2, output logic [15:0] rd);
    logic        s;
    logic [13:0] hdr;
    ta2 = 1'b1;
    rd  = 16'h0000;
    for (int i = 0; i < npre; i++) mbit(1'b1, s);
    hdr = {2'b01, opc, phy, ra};
    for (int i = 13; i >= 0; i--) mbit(hdr[i], s);
    if (opc == OP_READ) begin
      allow_drive = (phy == 5'd1);
      // TA bit 1: the line must still be released.
      mdc = 1'b0; master_bit = 1'b1;
      #80;
      check("ta1_hiz", {31'd0, o_mdio_t}, 32'd1);
      mdc = 1'b1;
      #80;
      mbit(1'b1, ta2);
      for (int i = 15; i >= 0; i--) begin
        if (i == abort_bit) begin
          @(negedge clk);
          rst = 1'b1;
          @(negedge clk);
          check("rst_release", {31'd0, o_mdio_t}, 32'd1);
          rst = 1'b0;
          allow_drive = 1'b0;
          return;
        end
        mbit(1'b1, s);
        rd[i] = s;
      end
      check("rd_release", {31'd0, o_mdio_t}, 32'd1);
      allow_drive = 1'b0;
    end else begin
      mbit(1'b1, s);
      mbit(1'b0, s);
      for (int i = 15; i >= 0; i--) mbit(wd[i], s);
    end
  endtask

  logic        ta2;
  logic [15:0] rdv;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 16'h0000;
    regs[2] = 16'h1234;
    regs[7] = 16'hBEEF;
    rst = 1'b1; mdc = 1'b1; master_bit = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_mdio_t", {31'd0, o_mdio_t}, 32'd1);
    check("rst_mdio", {31'd0, o_mdio}, 32'd0);
    check("rst_addr", {27'd0, o_reg_addr}, 32'd0);
    check("rst_wdata", {16'd0, o_reg_wdata}, 32'd0);
    check("rst_strobes", {29'd0, o_reg_rd, o_reg_wr, o_frame_err}, 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Write 0xA5C3 to register 4.
    push(K_WR, 5'h04, 16'hA5C3);
    frame(32, OP_WRITE, 5'd1, 5'h04, 16'hA5C3, -1, ta2, rdv);
    check("wr_addr_hold", {27'd0, o_reg_addr}, 32'h4);
    check("wr_data_hold", {16'd0, o_reg_wdata}, 32'hA5C3);

    // Read register 2.
    push(K_RD, 5'h02, 16'h0);
    frame(32, OP_READ, 5'd1, 5'h02, 16'h0, -1, ta2, rdv);
    check("rd_ta2", {31'd0, ta2}, 32'd0);
    check("rd_data_r2", {16'd0, rdv}, 32'h1234);
    check("wdata_hold_after_rd", {16'd0, o_reg_wdata}, 32'hA5C3);

    // Read for another PHY: ignored, then a valid read.
    frame(32, OP_READ, 5'd3, 5'h02, 16'h0, -1, ta2, rdv);
    check("mismatch_addr_hold", {27'd0, o_reg_addr}, 32'h2);
    push(K_RD, 5'h07, 16'h0);
    frame(32, OP_READ, 5'd1, 5'h07, 16'h0, -1, ta2, rdv);
    check("rd_data_r7", {16'd0, rdv}, 32'hBEEF);

    // Invalid opcode, then a valid write.
    push(K_ERR, 5'h0, 16'h0);
    frame(32, 2'b11, 5'd1, 5'h05, 16'h0000, -1, ta2, rdv);
    push(K_WR, 5'h09, 16'h0F0F);
    frame(32, OP_WRITE, 5'd1, 5'h09, 16'h0F0F, -1, ta2, rdv);
    check("wr_data_r9", {16'd0, o_reg_wdata}, 32'h0F0F);

    // Short preamble.
`ifdef MDIO_RESP_PREAMBLE_SUPPRESS_EN
    push(K_WR, 5'h0A, 16'h3C3C);
    frame(31, OP_WRITE, 5'd1, 5'h0A, 16'h3C3C, -1, ta2, rdv);
    check("short_pre_wdata", {16'd0, o_reg_wdata}, 32'h3C3C);
`else
    frame(31, OP_WRITE, 5'd1, 5'h0A, 16'h3C3C, -1, ta2, rdv);
    check("short_pre_wdata", {16'd0, o_reg_wdata}, 32'h0F0F);
    check("short_pre_addr", {27'd0, o_reg_addr}, 32'h09);
`endif

    // Reset during read data bit 7, then a complete read.
    push(K_RD, 5'h07, 16'h0);
    frame(32, OP_READ, 5'd1, 5'h07, 16'h0, 7, ta2, rdv);
    check("rst_addr_clear", {27'd0, o_reg_addr}, 32'h0);
    push(K_RD, 5'h02, 16'h0);
    frame(32, OP_READ, 5'd1, 5'h02, 16'h0, -1, ta2, rdv);
    check("rd_after_rst_ta2", {31'd0, ta2}, 32'd0);
    check("rd_after_rst_data", {16'd0, rdv}, 32'h1234);

    repeat (20) @(negedge clk);
    check("pending_expected", exp_q.size(), 32'd0);
    check("bus_violations", viol, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdio_responder.md
# mdio_responder

Clause-22 MDIO management responder (PHY side) for bidirectional pad wiring. Samples the MDC/MDIO pair in the system clock domain, decodes read and write frames addressed to its PHY address, and exposes a simple register-access port toward a local register file. Drives the shared MDIO line only during read turnaround and read data, through the same `iobuf_tech` pad (`o` to `i_mdio`, `i` from `o_mdio`, `t` from `o_mdio_t`).

## Interface
- `PHY_ADDR`, 5'd1, responder PHY address.
- `i_clk` in 1: system clock; must be at least 8x MDC frequency.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_mdc` in 1: MDC from pad, asynchronous.
- `i_mdio` in 1: MDIO pad input, asynchronous.
- `o_mdio` out 1: MDIO drive value.
- `o_mdio_t` out 1: pad tristate; 1 = high-Z.
- `o_reg_addr` out 5: register address of current or last frame.
- `o_reg_rd` out 1: read strobe, 1-cycle pulse.
- `i_reg_rdata` in 16: read data, valid 2 cycles after `o_reg_rd`.
- `o_reg_wr` out 1: write strobe, 1-cycle pulse.
- `o_reg_wdata` out 16: write data.
- `o_frame_err` out 1: 1-cycle pulse on an invalid ST or OP.

## Operation
- `i_mdc` and `i_mdio` each pass through a 2-FF synchronizer. A rising edge of synchronized MDC (`mdc_rise`) is the only bit event. `i_mdio` is sampled on `mdc_rise`.
- Frame format: ≥32 ones preamble, ST=01, OP (10=read, 01=write), PHYAD[4:0], REGAD[4:0], TA(2), DATA[15:0]. All fields MSB first.
- FSM states: PRE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA.
- PRE: ones counter saturates at 32.
  - 0 with count=32 → ST.
  - 0 with count<32 → count cleared, stay in PRE.
- ST: 1 → OP. 0 → `o_frame_err` pulse, PRE with count 0.
- OP: after 2 bits, 10 or 01 → PHYAD. Anything else → `o_frame_err`, PRE with count 0.
- PHYAD: after 5 bits, match → REGAD. Mismatch → PRE with count 0 silently; the line is never driven.
- REGAD: after 5 bits, `o_reg_addr` updates.
  - Read: `o_reg_rd` pulses the cycle after that `mdc_rise`.
  - Both ops go → TA.
- TA, read:
  - First TA bit period stays high-Z.
  - On the `mdc_rise` ending TA bit 1: `o_mdio_t`=0, `o_mdio`=0.
  - On the next `mdc_rise`: drive rdata[15] → RDATA.
- TA, write: both TA bits sampled and ignored → WDATA.
- RDATA: each `mdc_rise` shifts the next bit out. On the `mdc_rise` after bit 0 has been driven for one period: `o_mdio_t`=1 → PRE with count 0.
- WDATA: shift in 16 bits. The cycle after the 16th `mdc_rise`: `o_reg_wdata` updates and `o_reg_wr` pulses → PRE with count 0.
- `o_reg_addr` and `o_reg_wdata` hold their values until overwritten.
- Back-to-back frames without ≥32 ones in between are ignored, unless the preamble-suppression feature below is compiled in.

## Timing
- Reset values: `o_mdio_t`=1, `o_mdio`=0, `o_reg_addr`=0, `o_reg_wdata`=0, `o_reg_rd`=0, `o_reg_wr`=0, `o_frame_err`=0, state PRE, count 0.
- Reset mid-frame: pad released in the same cycle reset is sampled; no strobe is issued.
- Pin to `mdc_rise` latency: 3 `i_clk` cycles.
- MDIO output changes 1 `i_clk` after `mdc_rise`, i.e. ≤4 `i_clk` after the MDC pin rises.
- `i_reg_rdata` is captured exactly 2 cycles after `o_reg_rd`. This is always before TA completes, given the ≥8x clock ratio.
- `o_reg_rd` and `o_reg_wr` are never asserted in the same cycle.

## Configuration
- `MDIO_RESP_PREAMBLE_SUPPRESS_EN`
  - Defined: PRE accepts ST after a single 1 bit (count ≥1), supporting masters with preamble suppression.
  - Undefined: 32 ones are required.

## Structure
- Package `mdio_resp_pkg`:
  - state enum.
  - OP_READ=2'b10, OP_WRITE=2'b01.
  - PREAMBLE_LEN=32.
  - DATA_W=16, ADDR_W=5.
- Sub-module `mdio_sync`: 2-FF synchronizers for MDC and MDIO, plus the MDC rising-edge pulse.
- Pad `iobuf_tech` is instantiated by the parent, not inside this block.

## Test plan
- Write frame: 32 ones, ST, OP=01, PHYAD=1, REGAD=5'h04, TA=10, data 16'hA5C3 → `o_reg_wr` 1 pulse, `o_reg_addr`=4, `o_reg_wdata`=A5C3, `o_mdio_t` stays 1.
- Read frame: REGAD=5'h02, `i_reg_rdata`=16'h1234 → one `o_reg_rd` pulse; TA bit 2 reads 0; bus bits read back 0x1234; `o_mdio_t`=1 after bit 0.
- PHYAD=5'h03 read → no strobes, `o_mdio_t`=1 throughout; the next valid frame is still decoded.
- OP=11 → single `o_frame_err` pulse; the next valid frame is decoded.
- 31-one preamble then ST → ignored without the macro; decoded with `MDIO_RESP_PREAMBLE_SUPPRESS_EN`.
- `i_rst` asserted during RDATA bit 7 → `o_mdio_t`=1 next cycle; a following full read returns correct data.
